vpu_ub_writer: RTL
==================

Name: vpu_ub_writer

Overview:
- Receiving end of the VPU output stream: accepts the two valid-qualified VPU output lanes and commits them to the unified buffer (UB) as packed rows.
- Absorbs the one-cycle systolic skew between lane 1 and lane 2 with per-lane FIFOs, generates strided UB addresses, honours UB write backpressure, and reports completion or overflow to the controller.

Parameters:
DATA_W, 16, width of one lane sample (signed fixed point, passed through unmodified)
ADDR_W, 16, UB word address width
ROW_W, 8, width of row count / row index
FIFO_DEPTH, 4, entries per lane FIFO (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; latches base_addr/row_stride/num_rows, begins transfer
base_addr  in  ADDR_W  UB address of row 0
row_stride  in  ADDR_W  address increment per row
num_rows  in  ROW_W  rows to write (0 allowed)
vpu_data_in_1  in  DATA_W  lane 1 sample from VPU
vpu_data_in_2  in  DATA_W  lane 2 sample from VPU
vpu_valid_in_1  in  1  lane 1 sample valid
vpu_valid_in_2  in  1  lane 2 sample valid
ub_wr_ready  in  1  UB accepts write this cycle
ub_wr_en  out  1  write request (valid)
ub_wr_addr  out  ADDR_W  write address
ub_wr_data  out  2*DATA_W  {lane2, lane1}
busy  out  1  high in RUN
done  out  1  one-cycle pulse when last row is accepted by UB
overflow  out  1  sticky; a sample was dropped because its lane FIFO was full

Behaviour:
- Reset (rst_n low at edge): state IDLE, FIFOs empty, counters 0, ub_wr_en/busy/done/overflow = 0, ub_wr_addr/ub_wr_data = 0. Reset mid-transfer discards all buffered data; no write issued in the cycle after reset.
- States: IDLE -> RUN on start (busy=1 the next cycle). RUN -> IDLE when the final row handshake completes; done=1 in the cycle after that handshake. start with num_rows=0: no writes, done pulses the cycle after start, stays IDLE. start while in RUN is ignored.
- Lane acceptance (RUN only): lane k pushes its sample when valid_in_k=1 and its accept counter < num_rows; the counter then increments. Samples in IDLE, or beyond num_rows on a lane, are silently dropped without setting overflow.
- FIFO: a pushed sample is visible at the head the following cycle. Push and pop in the same cycle are allowed when full (count unchanged, no overflow). A push to a full FIFO with no simultaneous pop drops the sample, sets overflow (cleared only by reset or start), and still increments the accept counter.
- Write handshake: ub_wr_en = RUN & both FIFOs non-empty; it depends only on registered state, never on ub_wr_ready. ub_wr_data = {head2, head1}, ub_wr_addr = addr register. Transfer occurs when ub_wr_en & ub_wr_ready: pop both heads, addr += row_stride, row_idx++. While ready=0, en/addr/data stay stable.
- Latency: with ready held high, a row is written 1 cycle after its later lane sample arrives. Sustained throughput is 1 row/cycle.
- Address arithmetic: unsigned modulo 2^ADDR_W; wrap-around is permitted and not flagged.
- Lane skew of up to FIFO_DEPTH-1 cycles is absorbed without overflow while ready=1.

Decomposition:
- Package vpu_ub_pkg: DATA_W/ADDR_W/ROW_W defaults, typedef lane_t (signed DATA_W), typedef ub_row_t (packed {lane_t l2, lane_t l1}), enum writer_state_t {IDLE, RUN}.
- Sub-module lane_fifo (DEPTH, lane_t): synchronous FIFO exposing push, pop, head, empty, full, instantiated twice.

Test Plan:
- Aligned stream: base=0x0100, stride=1, num_rows=3; lanes valid together with (1,-1),(2,-2),(3,-3), ready=1 -> writes 0x0100={0xFFFF,0x0001}, 0x0101={0xFFFE,0x0002}, 0x0102={0xFFFD,0x0003}; done 1 cycle after the last write; overflow=0.
- Skew: lane 2 lags lane 1 by 1 cycle, num_rows=4, stride=8, base=0 -> first write 1 cycle after the first lane-2 sample; addresses 0,8,16,24; data correctly paired.
- Backpressure: ready=0 for 5 cycles mid-transfer with FIFO_DEPTH=4 and 4 samples arriving -> en/addr/data stable, no overflow; a 5th sample arriving while full and stalled sets overflow and drops that sample.
- num_rows=0 -> no ub_wr_en; done pulses the cycle after start; extra valid samples are ignored.
- Reset mid-transfer (rst_n low 1 cycle after 2 of 4 rows written) -> all outputs 0, state IDLE; a new start writes from the new base with no stale data.
- Surplus and idle samples: 2 extra valid samples after num_rows, plus samples before start -> not written, overflow stays 0.

Source files
------------

// File: rtl/vpu_ub_writer_pkg.sv
// Shared types for the VPU -> unified buffer writer.
// Lane samples are signed fixed point and pass through untouched.
package vpu_ub_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int ROW_W  = 8;

  typedef logic signed [DATA_W-1:0] lane_t;
  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic [ROW_W-1:0]         row_t;

  typedef struct packed {
    lane_t l2;
    lane_t l1;
  } ub_row_t;

  typedef enum logic {
    IDLE,
    RUN
  } writer_state_t;

endpackage

// File: rtl/vpu_ub_writer_if.sv
// UB write port: valid/ready handshake carrying one packed row.
// The writer is master; the unified buffer is slave.
interface vpu_ub_writer_if;
  import vpu_ub_pkg::*;

  logic    ub_wr_en;
  addr_t   ub_wr_addr;
  ub_row_t ub_wr_data;
  logic    ub_wr_ready;

  modport master (
    output ub_wr_en,
    output ub_wr_addr,
    output ub_wr_data,
    input  ub_wr_ready
  );

  modport slave (
    input  ub_wr_en,
    input  ub_wr_addr,
    input  ub_wr_data,
    output ub_wr_ready
  );

endinterface

// File: rtl/vpu_ub_writer_fifo.sv
// Per-lane synchronous FIFO; a push is visible at head next cycle.
// A push into a full FIFO only lands if a pop frees a slot the same cycle.
module lane_fifo
  import vpu_ub_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  push,
  input  lane_t din,
  input  logic  pop,
  output lane_t head,
  output logic  empty,
  output logic  full
);

  localparam int AW = $clog2(DEPTH);

  lane_t          mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    cnt;
  logic           do_pop;
  logic           do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign head    = mem[rptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is cleared on reset so the data bus reads zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr] <= din;
    end
  end

endmodule

// File: rtl/vpu_ub_writer.sv
// Packs the two skewed VPU lanes into UB rows at strided addresses.
// Write request depends only on registered state, never on ready.
module vpu_ub_writer
  import vpu_ub_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  addr_t base_addr,
  input  addr_t row_stride,
  input  row_t  num_rows,
  input  lane_t vpu_data_in_1,
  input  lane_t vpu_data_in_2,
  input  logic  vpu_valid_in_1,
  input  logic  vpu_valid_in_2,
  vpu_ub_writer_if.master ub,
  output logic  busy,
  output logic  done,
  output logic  overflow
);

  writer_state_t state;
  addr_t         addr_q;
  addr_t         stride_q;
  row_t          rows_q;
  row_t          row_idx;
  row_t          acc1;
  row_t          acc2;
  logic          done_q;
  logic          ovf_q;

  logic  run;
  logic  go;
  logic  push1;
  logic  push2;
  logic  pop;
  logic  wr_en;
  logic  drop;
  logic  last;
  logic  empty1;
  logic  empty2;
  logic  full1;
  logic  full2;
  lane_t head1;
  lane_t head2;

  assign run   = (state == RUN);
  assign go    = start & ~run;
  assign push1 = run & vpu_valid_in_1 & (acc1 < rows_q);
  assign push2 = run & vpu_valid_in_2 & (acc2 < rows_q);
  assign wr_en = run & ~empty1 & ~empty2;
  assign pop   = wr_en & ub.ub_wr_ready;
  assign last  = (row_t'(row_idx + 1'b1) == rows_q);

  // Only a push into a full FIFO with no pop that cycle loses data.
  assign drop  = (push1 & full1 & ~pop) |
                 (push2 & full2 & ~pop);

  lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .push  (push1),
    .din   (vpu_data_in_1),
    .pop   (pop),
    .head  (head1),
    .empty (empty1),
    .full  (full1)
  );

  lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .push  (push2),
    .din   (vpu_data_in_2),
    .pop   (pop),
    .head  (head2),
    .empty (empty2),
    .full  (full2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      rows_q   <= '0;
      row_idx  <= '0;
      acc1     <= '0;
      acc2     <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            stride_q <= row_stride;
            rows_q   <= num_rows;
            row_idx  <= '0;
            acc1     <= '0;
            acc2     <= '0;
            ovf_q    <= 1'b0;
            if (num_rows == '0) done_q <= 1'b1;
            else                state  <= RUN;
          end
        end
        RUN: begin
          if (push1) acc1  <= acc1 + 1'b1;
          if (push2) acc2  <= acc2 + 1'b1;
          if (drop)  ovf_q <= 1'b1;
          if (pop) begin
            addr_q  <= addr_q + stride_q;
            row_idx <= row_idx + 1'b1;
            if (last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ub.ub_wr_en      = wr_en;
  assign ub.ub_wr_addr    = addr_q;
  assign ub.ub_wr_data.l2 = head2;
  assign ub.ub_wr_data.l1 = head1;

  assign busy     = run;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
